// File: rtl/dds_pkg.sv
// Shared AD9959 definitions for the DDS sweep path: register map, channel masks,
// sweep FSM states and the FTW stepping helper.
package dds_pkg;

    localparam int FTW_W = 32;

    localparam logic [7:0] ADDR_CSR   = 8'h00;
    localparam logic [7:0] ADDR_FR1   = 8'h01;
    localparam logic [7:0] ADDR_CFTW0 = 8'h04;
    localparam logic [7:0] ADDR_CPOW0 = 8'h05;
    localparam logic [7:0] ADDR_ACR   = 8'h06;

    localparam logic [3:0] CH0 = 4'b0001;
    localparam logic [3:0] CH1 = 4'b0010;
    localparam logic [3:0] CH2 = 4'b0100;
    localparam logic [3:0] CH3 = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_DWELL    = 2'd3
    } sweep_state_e;

    // Tuning words wrap modulo 2^32; a negative f_step is plain two's complement.
    function automatic logic [FTW_W-1:0] ftw_step(input logic [FTW_W-1:0] ftw,
                                                   input logic [FTW_W-1:0] step,
                                                   input logic             down);
        return down ? (ftw - step) : (ftw + step);
    endfunction

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Write-request handshake between the sweep scheduler (master) and the DDS
// serial write engine (slave).
interface dds_sweep_ctrl_if;
    import dds_pkg::*;

    logic             wr_req;
    logic [FTW_W-1:0] wr_ftw;
    logic [3:0]       wr_mask;
    logic             wr_ack;

    modport master (output wr_req, output wr_ftw, output wr_mask, input wr_ack);
    modport slave  (input wr_req, input wr_ftw, input wr_mask, output wr_ack);

endinterface

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter timing the idle gap between a write ack and the next
// request; expired is high while the count sits at zero.
module dds_dwell_timer #(
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] load_val_i,
    input  logic               count_i,
    output logic               expired_o
);

    logic [DWELL_W-1:0] cnt_q;

    // Count register: load wins over decrement, stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (count_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - DWELL_W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// AD9959 frequency-sweep scheduler: steps an FTW and issues one engine write per
// step with a programmed dwell. Define DDS_SWEEP_PINGPONG_EN for a continuous triangle sweep.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int DWELL_W = 24,
    parameter int STEP_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [FTW_W-1:0]   f_start,
    input  logic [FTW_W-1:0]   f_step,
    input  logic [STEP_W-1:0]  n_steps,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [3:0]         ch_mask,
    dds_sweep_ctrl_if.master   wr,
    output logic               busy,
    output logic               done,
    output logic [STEP_W-1:0]  step_idx
);

    sweep_state_e       state_q;
    logic [FTW_W-1:0]   f_step_q;
    logic [STEP_W-1:0]  n_steps_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [FTW_W-1:0]   ftw_q;
    logic [STEP_W-1:0]  idx_q;
    logic               stop_pend_q;
    logic               busy_q;
    logic               done_q;
    logic               wr_req_q;
    logic [FTW_W-1:0]   wr_ftw_q;
    logic [3:0]         wr_mask_q;

    logic [FTW_W-1:0]   ftw_d;
    logic [STEP_W-1:0]  idx_d;
    logic               sweep_end_s;
    logic               tmr_load_s;
    logic               tmr_count_s;
    logic               tmr_expired_s;

`ifdef DDS_SWEEP_PINGPONG_EN
    logic dir_q;
    logic dir_d;

    // Triangle stepping: reverse at either end; n_steps=0 holds f_start.
    always_comb begin
        dir_d = dir_q;
        ftw_d = ftw_q;
        idx_d = idx_q;
        if (n_steps_q == '0) begin
            dir_d = 1'b0;
        end else if (!dir_q) begin
            if (idx_q == n_steps_q) begin
                dir_d = 1'b1;
                ftw_d = ftw_step(ftw_q, f_step_q, 1'b1);
                idx_d = idx_q - STEP_W'(1);
            end else begin
                ftw_d = ftw_step(ftw_q, f_step_q, 1'b0);
                idx_d = idx_q + STEP_W'(1);
            end
        end else begin
            if (idx_q == '0) begin
                dir_d = 1'b0;
                ftw_d = ftw_step(ftw_q, f_step_q, 1'b0);
                idx_d = idx_q + STEP_W'(1);
            end else begin
                ftw_d = ftw_step(ftw_q, f_step_q, 1'b1);
                idx_d = idx_q - STEP_W'(1);
            end
        end
    end

    assign sweep_end_s = 1'b0;
`else
    // Single-shot up-sweep stepping.
    always_comb begin
        ftw_d = ftw_step(ftw_q, f_step_q, 1'b0);
        idx_d = idx_q + STEP_W'(1);
    end

    assign sweep_end_s = (idx_q == n_steps_q);
`endif

    assign tmr_load_s  = (state_q == ST_WAIT_ACK) && wr.wr_ack;
    assign tmr_count_s = (state_q == ST_DWELL);

    dds_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load_s),
        .load_val_i (dwell_q),
        .count_i    (tmr_count_s),
        .expired_o  (tmr_expired_s)
    );

    // Sweep FSM with all outputs registered; done is a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            f_step_q    <= '0;
            n_steps_q   <= '0;
            dwell_q     <= '0;
            ftw_q       <= '0;
            idx_q       <= '0;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_req_q    <= 1'b0;
            wr_ftw_q    <= '0;
            wr_mask_q   <= 4'b0000;
`ifdef DDS_SWEEP_PINGPONG_EN
            dir_q       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        f_step_q    <= f_step;
                        n_steps_q   <= n_steps;
                        dwell_q     <= dwell;
                        ftw_q       <= f_start;
                        wr_ftw_q    <= f_start;
                        wr_mask_q   <= ch_mask;
                        idx_q       <= '0;
                        busy_q      <= 1'b1;
                        stop_pend_q <= stop;
`ifdef DDS_SWEEP_PINGPONG_EN
                        dir_q       <= 1'b0;
`endif
                        state_q     <= ST_ISSUE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    wr_req_q <= 1'b1;
                    if (stop) begin
                        stop_pend_q <= 1'b1;
                    end
                    state_q <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (wr.wr_ack) begin
                        wr_req_q <= 1'b0;
                        if (stop_pend_q || stop || sweep_end_s) begin
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            stop_pend_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            ftw_q   <= ftw_d;
                            idx_q   <= idx_d;
`ifdef DDS_SWEEP_PINGPONG_EN
                            dir_q   <= dir_d;
`endif
                            state_q <= ST_DWELL;
                        end
                    end else if (stop) begin
                        stop_pend_q <= 1'b1;
                    end
                end
                ST_DWELL: begin
                    // No write is in flight here, so stop exits without one.
                    if (stop) begin
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        stop_pend_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else if (tmr_expired_s) begin
                        wr_ftw_q <= ftw_q;
                        state_q  <= ST_ISSUE;
                    end else begin
                        state_q <= ST_DWELL;
                    end
                end
                default: begin
                    wr_req_q    <= 1'b0;
                    busy_q      <= 1'b0;
                    stop_pend_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr.wr_req  = wr_req_q;
    assign wr.wr_ftw  = wr_ftw_q;
    assign wr.wr_mask = wr_mask_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign step_idx   = idx_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed self-checking bench for dds_sweep_ctrl; the engine side is modelled by
// the tasks that drive wr_ack.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] f_start = 32'h0;
    logic [31:0] f_step = 32'h0;
    logic [15:0] n_steps = 16'h0;
    logic [23:0] dwell = 24'h0;
    logic [3:0]  ch_mask = 4'h0;
    logic        ack = 1'b0;
    logic        busy, done;
    logic [15:0] step_idx;
    int          n_cmp = 0;
    int          n_err = 0;

    dds_sweep_ctrl_if wr_bus ();
    assign wr_bus.wr_ack = ack;

    dds_sweep_ctrl #(.DWELL_W(24), .STEP_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .f_start(f_start), .f_step(f_step), .n_steps(n_steps), .dwell(dwell),
        .ch_mask(ch_mask), .wr(wr_bus), .busy(busy), .done(done), .step_idx(step_idx)
    );

    always #5 clk = ~clk;

    task automatic wait_req(input int limit, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < limit && !ok) begin
            if (wr_bus.wr_req === 1'b1) ok = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    task automatic send_ack(input int delay);
        repeat (delay) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (wr_bus.wr_req !== 1'b0) begin n_err++; $display("FAIL reset_wr_req: got %b want 0", wr_bus.wr_req); end
        n_cmp++; if (wr_bus.wr_ftw !== 32'h0) begin n_err++; $display("FAIL reset_wr_ftw: got %h want 0", wr_bus.wr_ftw); end
        n_cmp++; if (wr_bus.wr_mask !== 4'h0) begin n_err++; $display("FAIL reset_wr_mask: got %h want 0", wr_bus.wr_mask); end
        n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL reset_busy_done: got %b want 00", {busy, done}); end
        n_cmp++; if (step_idx !== 16'h0) begin n_err++; $display("FAIL reset_step_idx: got %h want 0", step_idx); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_sweep();
        logic [31:0] exp_ftw [4];
        int cyc, dones, reqs, gap;
        bit ok;
        exp_ftw = '{32'h0100_0000, 32'h0110_0000, 32'h0120_0000, 32'h0130_0000};
        f_start = 32'h0100_0000; f_step = 32'h0010_0000; n_steps = 16'd3; dwell = 24'd10; ch_mask = 4'b0011;
        pulse_start();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_after_start: got %b want 1", busy); end
        n_cmp++; if (wr_bus.wr_req !== 1'b0) begin n_err++; $display("FAIL basic_req_latency: got %b want 0", wr_bus.wr_req); end
        for (int i = 0; i < 4; i++) begin
            wait_req(40, cyc, ok);
            gap = (i == 0) ? 1 : 12;
            n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_req_timeout: write %0d never requested", i); end
            n_cmp++; if (cyc != gap) begin n_err++; $display("FAIL basic_req_gap: write %0d got %0d want %0d", i, cyc, gap); end
            n_cmp++; if (wr_bus.wr_ftw !== exp_ftw[i]) begin n_err++; $display("FAIL basic_ftw: write %0d got %h want %h", i, wr_bus.wr_ftw, exp_ftw[i]); end
            n_cmp++; if (wr_bus.wr_mask !== 4'b0011) begin n_err++; $display("FAIL basic_mask: got %h want 3", wr_bus.wr_mask); end
            n_cmp++; if (step_idx !== 16'(i)) begin n_err++; $display("FAIL basic_step_idx: got %0d want %0d", step_idx, i); end
            send_ack(5);
            n_cmp++; if (wr_bus.wr_req !== 1'b0) begin n_err++; $display("FAIL basic_req_drop: got %b want 0", wr_bus.wr_req); end
            n_cmp++; if (done !== (i == 3)) begin n_err++; $display("FAIL basic_done: write %0d got %b", i, done); end
            n_cmp++; if (busy !== (i != 3)) begin n_err++; $display("FAIL basic_busy: write %0d got %b", i, busy); end
        end
        dones = 0; reqs = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (wr_bus.wr_req === 1'b1) reqs++;
        end
        n_cmp++; if (dones != 0) begin n_err++; $display("FAIL basic_single_done: got %0d extra done cycles want 0", dones); end
        n_cmp++; if (reqs != 0) begin n_err++; $display("FAIL basic_no_extra_req: got %0d want 0", reqs); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_ftw [2];
        int cyc;
        bit ok;
        exp_ftw = '{32'hFFFF_FFF0, 32'h0000_0010};
        f_start = 32'hFFFF_FFF0; f_step = 32'h0000_0020; n_steps = 16'd1; dwell = 24'd3; ch_mask = 4'b0101;
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            wait_req(40, cyc, ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL wrap_req_timeout: write %0d", i); end
            n_cmp++; if (wr_bus.wr_ftw !== exp_ftw[i]) begin n_err++; $display("FAIL wrap_ftw: write %0d got %h want %h", i, wr_bus.wr_ftw, exp_ftw[i]); end
            send_ack(2);
        end
        n_cmp++; if ({done, busy} !== 2'b10) begin n_err++; $display("FAIL wrap_done_busy: got %b want 10", {done, busy}); end
        @(negedge clk);
    endtask

    task automatic test_stop_in_wait();
        logic [31:0] held;
        int cyc, bad, reqs;
        bit ok;
        f_start = 32'h0200_0000; f_step = 32'h0000_0100; n_steps = 16'd3; dwell = 24'd2; ch_mask = 4'b1000;
        pulse_start();
        wait_req(40, cyc, ok);
        send_ack(2);
        wait_req(40, cyc, ok);
        n_cmp++; if (wr_bus.wr_ftw !== 32'h0200_0100) begin n_err++; $display("FAIL stopw_ftw: got %h want 02000100", wr_bus.wr_ftw); end
        held = wr_bus.wr_ftw;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        bad = 0;
        repeat (20) begin
            if (wr_bus.wr_req !== 1'b1 || wr_bus.wr_ftw !== held) bad++;
            @(negedge clk);
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL stopw_held: got %0d unstable cycles want 0", bad); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        n_cmp++; if ({wr_bus.wr_req, done, busy} !== 3'b010) begin n_err++; $display("FAIL stopw_exit: req/done/busy got %b want 010", {wr_bus.wr_req, done, busy}); end
        n_cmp++; if (step_idx !== 16'd1) begin n_err++; $display("FAIL stopw_step_idx: got %0d want 1", step_idx); end
        reqs = 0;
        repeat (30) begin
            @(negedge clk);
            if (wr_bus.wr_req === 1'b1) reqs++;
        end
        n_cmp++; if (reqs != 0) begin n_err++; $display("FAIL stopw_no_req: got %0d want 0", reqs); end
    endtask

    task automatic test_stop_in_dwell();
        int cyc, reqs;
        bit ok;
        f_start = 32'h0300_0000; f_step = 32'h0000_0001; n_steps = 16'd3; dwell = 24'd20; ch_mask = 4'b0001;
        pulse_start();
        wait_req(40, cyc, ok);
        send_ack(2);
        n_cmp++; if (step_idx !== 16'd1) begin n_err++; $display("FAIL stopd_step_idx: got %0d want 1", step_idx); end
        repeat (3) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_cmp++; if ({done, busy} !== 2'b10) begin n_err++; $display("FAIL stopd_exit: done/busy got %b want 10", {done, busy}); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL stopd_done_pulse: got %b want 0", done); end
        reqs = 0;
        repeat (40) begin
            @(negedge clk);
            if (wr_bus.wr_req === 1'b1) reqs++;
        end
        n_cmp++; if (reqs != 0) begin n_err++; $display("FAIL stopd_no_req: got %0d want 0", reqs); end
    endtask

    task automatic test_start_while_busy();
        logic [31:0] exp_ftw [3];
        int cyc;
        bit ok;
        exp_ftw = '{32'h0000_1000, 32'h0000_1010, 32'h0000_1020};
        f_start = 32'h0000_1000; f_step = 32'h0000_0010; n_steps = 16'd2; dwell = 24'd4; ch_mask = 4'b0110;
        pulse_start();
        wait_req(40, cyc, ok);
        f_start = 32'hDEAD_BEEF; f_step = 32'h0000_5555; n_steps = 16'd9; ch_mask = 4'b1111;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            wait_req(40, cyc, ok);
            n_cmp++; if (wr_bus.wr_ftw !== exp_ftw[i] || wr_bus.wr_mask !== 4'b0110) begin
                n_err++; $display("FAIL busy_start_ftw: write %0d got %h/%h want %h/6", i, wr_bus.wr_ftw, wr_bus.wr_mask, exp_ftw[i]);
            end
            send_ack(1);
        end
        n_cmp++; if ({done, busy} !== 2'b10) begin n_err++; $display("FAIL busy_start_done: got %b want 10", {done, busy}); end
        @(negedge clk);
    endtask

    task automatic test_single();
        int cyc, reqs;
        bit ok;
        f_start = 32'h1234_5678; f_step = 32'h0000_0100; n_steps = 16'd0; dwell = 24'd0; ch_mask = 4'b0010;
        pulse_start();
        wait_req(40, cyc, ok);
        n_cmp++; if (!ok || cyc != 1) begin n_err++; $display("FAIL single_req: ok %0d latency %0d want 1", ok, cyc); end
        n_cmp++; if (wr_bus.wr_ftw !== 32'h1234_5678) begin n_err++; $display("FAIL single_ftw: got %h want 12345678", wr_bus.wr_ftw); end
        send_ack(1);
        n_cmp++; if ({done, busy, wr_bus.wr_req} !== 3'b100) begin n_err++; $display("FAIL single_done: got %b want 100", {done, busy, wr_bus.wr_req}); end
        reqs = 0;
        repeat (20) begin
            @(negedge clk);
            if (wr_bus.wr_req === 1'b1) reqs++;
        end
        n_cmp++; if (reqs != 0) begin n_err++; $display("FAIL single_no_req: got %0d want 0", reqs); end
    endtask

    task automatic test_reset_mid();
        int cyc, reqs;
        bit ok;
        f_start = 32'hAAAA_0000; f_step = 32'h0000_0001; n_steps = 16'd5; dwell = 24'd3; ch_mask = 4'b1001;
        pulse_start();
        wait_req(40, cyc, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rstmid_req: got no request"); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({wr_bus.wr_req, busy} !== 2'b00) begin n_err++; $display("FAIL rstmid_async: req/busy got %b want 00", {wr_bus.wr_req, busy}); end
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if (wr_bus.wr_ftw !== 32'h0 || step_idx !== 16'h0) begin n_err++; $display("FAIL rstmid_regs: ftw %h idx %0d want 0/0", wr_bus.wr_ftw, step_idx); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        n_cmp++; if ({wr_bus.wr_req, done, busy} !== 3'b000) begin n_err++; $display("FAIL rstmid_spurious_ack: got %b want 000", {wr_bus.wr_req, done, busy}); end
        reqs = 0;
        repeat (10) begin
            @(negedge clk);
            if (wr_bus.wr_req === 1'b1) reqs++;
        end
        n_cmp++; if (reqs != 0) begin n_err++; $display("FAIL rstmid_no_req: got %0d want 0", reqs); end
    endtask

`ifdef DDS_SWEEP_PINGPONG_EN
    task automatic test_pingpong();
        logic [31:0] exp_seq [7];
        int cyc;
        bit ok;
        exp_seq = '{32'd0, 32'd1, 32'd2, 32'd1, 32'd0, 32'd1, 32'd2};
        f_start = 32'h0; f_step = 32'h1; n_steps = 16'd2; dwell = 24'd1; ch_mask = 4'b1111;
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            wait_req(40, cyc, ok);
            n_cmp++; if (!ok || wr_bus.wr_ftw !== exp_seq[i] || step_idx !== exp_seq[i][15:0]) begin
                n_err++; $display("FAIL pingpong_seq: write %0d got %h idx %0d want %h", i, wr_bus.wr_ftw, step_idx, exp_seq[i]);
            end
            if (i == 6) begin
                stop = 1'b1;
                @(negedge clk);
                stop = 1'b0;
            end
            send_ack(1);
            n_cmp++; if ({done, busy} !== ((i == 6) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL pingpong_done_busy: write %0d got %b", i, {done, busy}); end
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
`ifdef DDS_SWEEP_PINGPONG_EN
        test_pingpong();
`else
        test_basic_sweep();
        test_wrap();
        test_stop_in_wait();
        test_stop_in_dwell();
        test_start_while_busy();
        test_single();
        test_reset_mid();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep scheduler for the AD9959 four-channel DDS path. It sits upstream of the DDS serial write engine. It steps a 32-bit frequency tuning word (FTW) from a start value by a signed step for a programmed number of steps, and issues one write request per step to the engine. Each step is held for a programmed dwell before the next. Control comes from a start/stop pulse pair, and status is reported as busy/done/step index.

## Interface
Parameters:
- DWELL_W, 24, width of dwell counter (cycles of clk)
- STEP_W, 16, width of step count / step index

Ports:
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle start pulse; ignored while busy
- stop  in  1  single-cycle stop request
- f_start  in  32  first FTW
- f_step  in  32  FTW increment, two's complement
- n_steps  in  STEP_W  number of increments after first word (total writes = n_steps+1)
- dwell  in  DWELL_W  idle cycles between write completion and next request
- ch_mask  in  4  channel-select mask (CSR bits 7:4 value)
- wr_req  out  1  write request to serial engine
- wr_ftw  out  32  FTW for current write
- wr_mask  out  4  channel mask for current write
- wr_ack  in  1  one-cycle pulse from engine: write + I/O update complete
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep completion or stop
- step_idx  out  STEP_W  index of current/last issued step

## Operation
- States: IDLE, ISSUE, WAIT_ACK, DWELL.
- IDLE: start=1 latches f_start, f_step, n_steps, dwell, ch_mask into shadow regs; ftw←f_start, step_idx←0, busy←1 → ISSUE. Inputs are not re-sampled until next start.
- ISSUE: wr_req←1 → WAIT_ACK.
- WAIT_ACK: wr_req, wr_ftw, wr_mask held stable until wr_ack. On wr_ack: wr_req←0.
  - If stop_pending or step_idx==n_steps → IDLE, busy←0, done pulse.
  - Else ftw←ftw+f_step (mod 2^32, wrap silently), step_idx+1 → DWELL.
- DWELL: count dwell cycles, then → ISSUE. dwell=0 → ISSUE next cycle.
- stop: latched into stop_pending in any busy state.
  - In DWELL: → IDLE next cycle, done pulse.
  - In ISSUE/WAIT_ACK: the in-flight write always completes; exit on its ack.
  - stop in IDLE has no effect.
- start and stop in the same cycle in IDLE: start wins, stop_pending←1. Exactly one write is issued, then done.
- wr_ack outside WAIT_ACK: ignored.
- n_steps=0: single write of f_start.

## Timing
- Reset values: wr_req=0, wr_ftw=0, wr_mask=0, busy=0, done=0, step_idx=0, state IDLE, stop_pending=0. Reset mid-transfer drops wr_req immediately (async).
- start sampled at edge N → busy=1 after N. wr_req=1 after N+1.
- wr_ack sampled at edge M → wr_req=0 after M.
- Next wr_req=1 after edge M+dwell+2.
- Final ack at M → done=1 for the cycle after M; busy=0 same cycle.
- wr_ftw/wr_mask update only on transition into ISSUE; constant while wr_req=1.

## Configuration
- DDS_SWEEP_PINGPONG_EN defined:
  - At step_idx==n_steps, direction reverses (ftw←ftw−f_step, step_idx counts down). Direction reverses again at step_idx==0.
  - The sweep runs as a continuous triangle until stop; done pulses only on stop.
  - step_idx reports position, 0..n_steps.
  - n_steps=0 repeats f_start continuously.
- Undefined: single-shot up-sweep as above; no direction register synthesized.

## Structure
- Shared package dds_pkg:
  - AD9959 register addresses (CSR 8'h00, FR1 8'h01, CFTW0 8'h04, CPOW0 8'h05, ACR 8'h06).
  - Channel mask constants CH0..CH3 (4'b0001..4'b1000).
  - Sweep state enum.
  - FTW width constant 32.
- Sub-module dds_dwell_timer: loadable down-counter (load, count, expired), DWELL_W wide.
- The serial engine is not part of this block.

## Test plan
- f_start=32'h0100_0000, f_step=32'h0010_0000, n_steps=3, dwell=10, engine acks 5 cycles after req → four writes: 0100_0000, 0110_0000, 0120_0000, 0130_0000; request gaps = dwell+2 cycles after each ack; single done pulse; busy low after.
- f_start=32'hFFFF_FFF0, f_step=32'h20, n_steps=1 → writes FFFF_FFF0 then 0000_0010 (wrap).
- Stop asserted while wr_req=1 on step 1, ack delayed 20 cycles → wr_req held with unchanged wr_ftw until ack, then IDLE, done, step_idx=1, no further req.
- Stop during DWELL → no further req, done next cycle.
- start during busy with new f_start → ignored; sweep continues with original words.
- n_steps=0, dwell=0 → exactly one write of f_start, done after its ack.
- rst_n low while wr_req=1 → wr_req=0 immediately; after release, spurious wr_ack is ignored.
- DDS_SWEEP_PINGPONG_EN, n_steps=2, f_step=1, f_start=0 → sequence 0,1,2,1,0,1… until stop.
